// File: rtl/pearson_pkg.sv
// Pearson hash package shared by the checker and the hash generator.
// Holds the 256-entry permutation table, a single-step helper and the checker FSM states.
package pearson_pkg;

  localparam logic [7:0] PEARSON_T [256] = '{
    251, 175, 119, 215,  81,  14,  79, 191, 103,  49, 181, 143, 186, 157,   0, 232,
     31,  32,  55,  60, 152,  58,  17, 237, 174,  70, 160, 144, 220,  90,  57, 223,
     59,   3,  18, 140, 111, 166, 203, 196, 134, 243, 124,  95, 222, 179, 197,  65,
    180,  48,  36,  15, 107,  46, 233, 130, 165,  30, 123, 161, 209,  23,  97,  16,
     40,  91, 219,  61, 100,  10, 210, 109, 250, 127,  22, 138,  29, 108, 244,  67,
    207,   9, 178, 204,  74,  98, 126, 249, 167, 116,  34,  77, 193, 200, 121,   5,
     20, 113,  71,  35, 128,  13, 182,  94,  25, 226, 227, 199,  75,  27,  41, 245,
    230, 224,  43, 225, 177,  26, 155, 150, 212, 142, 218, 115, 241,  73,  88, 105,
     39, 114,  62, 255, 192, 201, 145, 214, 168, 158, 221, 148, 154, 122,  12,  84,
     82, 163,  44, 139, 228, 236, 205, 242, 217,  11, 187, 146, 159,  64,  86, 239,
    195,  42, 106, 198, 118, 112, 184, 172,  87,   2, 173, 117, 176, 229, 247, 253,
    137, 185,  99, 164, 102, 147,  45,  66, 231,  52, 141, 211, 194, 206, 246, 238,
     56, 110,  78, 248,  63, 240, 189,  93,  92,  51,  53, 183,  19, 171,  72,  50,
     33, 104, 101,  69,   8, 252,  83, 120,  76, 135,  85,  54, 202, 125, 188, 213,
     96, 235, 136, 208, 162, 129, 190, 132, 156,  38,  47,   1,   7, 254,  24,   4,
    216, 131,  89,  21,  28, 133,  37, 153, 149,  80, 170,  68,   6, 169, 234, 151
  };

  // One hash step: fold byte b into running hash h.
  function automatic logic [7:0] pearson_step(input logic [7:0] h, input logic [7:0] b);
    return PEARSON_T[h ^ b];
  endfunction

  typedef enum logic [0:0] {
    RECV   = 1'b0,
    REPORT = 1'b1
  } state_e;

endpackage

// File: rtl/pearson_check_if.sv
// Byte-stream input and result handshake of the Pearson frame checker.
// master: frame source / result consumer; slave: the checker.
interface pearson_check_if #(
  parameter int unsigned LEN_W = 8
) ();

  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [7:0]       res_hash;
  logic [LEN_W-1:0] res_len;
  logic             res_ovf;

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_ok, res_hash, res_len, res_ovf
  );

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_ok, res_hash, res_len, res_ovf
  );

endinterface

// File: rtl/pearson_lut.sv
// Combinational Pearson permutation lookup.
// Ports: idx - 8-bit table index; val - permuted 8-bit value.
module pearson_lut
  import pearson_pkg::*;
(
  input  logic [7:0] idx,
  output logic [7:0] val
);

  assign val = PEARSON_T[idx];

endmodule

// File: rtl/pearson_check.sv
// Receive-side Pearson hash checker. Hashes each frame payload, compares the hash with
// the trailing check byte and presents match, hash, saturating length and overflow.
// Ports: clk, rst_n (async active-low); bus - slave side of pearson_check_if
// (s_valid/s_ready/s_data/s_last byte stream in, res_* result handshake out).
module pearson_check
  import pearson_pkg::*;
#(
  parameter logic [7:0]  SEED  = 8'h00,
  parameter int unsigned LEN_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  pearson_check_if.slave bus
);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [7:0]       h_q, h_d;
  logic [7:0]       step;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             res_ok_q, res_ok_d;
  logic [7:0]       res_hash_q, res_hash_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic             res_ovf_q, res_ovf_d;
  logic             accept;

  pearson_lut u_lut (
    .idx (h_q ^ bus.s_data),
    .val (step)
  );

  // ready_q is set only in RECV, so it alone qualifies acceptance.
  assign accept = bus.s_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    res_ok_d   = res_ok_q;
    res_hash_d = res_hash_q;
    res_len_d  = res_len_q;
    res_ovf_d  = res_ovf_q;
    unique case (state_q)
      RECV: begin
        if (accept) begin
          if (bus.s_last) begin
            // Check byte closes the frame and is not hashed.
            res_hash_d = h_q;
            res_ok_d   = (h_q == bus.s_data) && !ovf_q;
            res_len_d  = len_q;
            res_ovf_d  = ovf_q;
            state_d    = REPORT;
          end else begin
            h_d = step;
            if (len_q != '1) begin
              len_d = len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          state_d = RECV;
          h_d     = SEED;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = RECV;
    endcase
    // Registered so s_ready stays low in reset and has no path from res_ready.
    ready_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RECV;
      ready_q    <= 1'b0;
      h_q        <= SEED;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      res_ok_q   <= 1'b0;
      res_hash_q <= 8'h00;
      res_len_q  <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      h_q        <= h_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      res_ok_q   <= res_ok_d;
      res_hash_q <= res_hash_d;
      res_len_q  <= res_len_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign bus.s_ready   = ready_q;
  assign bus.res_valid = (state_q == REPORT);
  assign bus.res_ok    = res_ok_q;
  assign bus.res_hash  = res_hash_q;
  assign bus.res_len   = res_len_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule
